vx_tex_rsp_gather: RTL and testbench
====================================

// Module: VX_tex_rsp_gather
// PURPOSE
// - Master end of the texture response channel (valid/texels/tag/ready) back to the core.
// - Sits after the texture sampler and takes partial per-lane results (fragments) from it.
// - Merges each fragment stream into one full-width response and queues it in a FIFO.
// - Drives the response channel, honouring core backpressure.
// PARAMETERS
// - NUM_LANES  4  lanes per response; in_mask/rsp_texels width basis
// - TAG_WIDTH  8  opaque request tag width; returned unchanged
// - RSP_DEPTH  4  output FIFO entries; power of two, >=2
// PORTS
// - clk         in   1              clock; all logic on rising edge
// - reset       in   1              asynchronous, active-high reset
// - in_valid    in   1              sampler fragment valid
// - in_mask     in   NUM_LANES      lanes carried by this fragment
// - in_texels   in   NUM_LANES*32   texel data; only masked lanes meaningful
// - in_tag      in   TAG_WIDTH      tag; sampled on first fragment only
// - in_last     in   1              final fragment of this response
// - in_ready    out  1              fragment accepted when in_valid&in_ready
// - rsp_valid   out  1              response valid to core
// - rsp_texels  out  NUM_LANES*32   assembled texels, lane i = bits[32i+:32]
// - rsp_tag     out  TAG_WIDTH      response tag
// - rsp_ready   in   1              core accepts when rsp_valid&rsp_ready
// BEHAVIOUR
// - Reset (async assert, sync release): rsp_valid=0, rsp_texels=0, rsp_tag=0; FIFO empty.
//   Also at reset: state IDLE, staging texels/tag=0; perf_stalls=0 when compiled in.
// - in_ready = !fifo_full. Registered, does not depend on in_valid.
// - A fragment is accepted even when in_last=0. The core never sees partial data.
// - FSM IDLE: accepted fragment with in_last=0 -> GATHER.
//   * On that fragment: capture in_tag; clear staging.
//   * Write masked lanes.
// - FSM IDLE: accepted fragment with in_last=1 -> stay IDLE.
//   * Push {merged texels, in_tag} to the FIFO.
// - FSM GATHER: accepted fragment writes its masked lanes; in_tag is ignored.
//   * in_last=1: push {staging merged with fragment, captured tag} to the FIFO; -> IDLE.
// - Lanes never written in a response read 0.
// - A lane written twice: the later fragment wins.
// - in_mask=0: legal. No lane is written, but in_last is still honoured.
// - Latency: last fragment accepted in cycle N -> rsp_valid=1 in cycle N+1 (FIFO empty).
// - FIFO is show-ahead. rsp_* come from the head entry and hold stable while rsp_valid&!rsp_ready.
// - Full FIFO: in_ready=0 regardless of rsp_ready (no same-cycle pass-through).
//   * If a pop happens while full, in_ready rises the next cycle.
// - Empty FIFO: rsp_valid=0. rsp_texels/rsp_tag hold their last value.
// - Simultaneous push and pop: occupancy is unchanged.
// - Read/write pointers wrap modulo RSP_DEPTH. Count width is $clog2(RSP_DEPTH+1).
// - Reset mid-GATHER or with a non-empty FIFO discards all partial and queued data.
// - Sim-only assertions:
//   * in_tag equals the captured tag on GATHER fragments.
//   * rsp_* are stable under stall.
// CONFIGURATION
// - TEX_RSP_PERF_EN defined: add port perf_stalls out 32.
//   * Counts cycles with rsp_valid&!rsp_ready.
//   * Saturates at 32'hFFFFFFFF; reset to 0.
// - TEX_RSP_PERF_EN undefined: port and counter are absent; datapath unchanged.
// TESTING
// - Single fragment, mask=4'hF, last=1, tag=8'h3C, rsp_ready=1.
//   -> Next cycle: rsp_valid=1, tag=8'h3C, all four lanes match the input.
// - Two fragments: mask=4'b0011 (tag 8'h11), then mask=4'b1100 last=1 (tag 8'h22).
//   -> One response, tag 8'h11, all lanes merged.
// - Fragment mask=4'b0101 with last=1.
//   -> Lanes 1 and 3 are 0; lanes 0 and 2 match the input.
// - rsp_ready=0, push 4 responses (RSP_DEPTH=4).
//   -> in_ready=0 after the 4th.
//   -> rsp_* hold entry 0; perf_stalls increments each stall cycle.
// - Full FIFO, raise rsp_ready for 1 cycle.
//   -> Entry 0 pops; in_ready=1 the next cycle; order is preserved across pointer wrap.
// - Assert reset mid-GATHER with 2 entries queued.
//   -> rsp_valid=0 immediately, in_ready=1, next response has no stale lanes.

Source files
------------

// File: rtl/vx_tex_rsp_gather.sv
// vx_tex_rsp_gather
//   Master end of the texture response channel back to the core. It gathers
//   partial per-lane fragments from the sampler into one full-width response.
//   Each finished response is queued in a show-ahead FIFO. The response
//   channel is driven from the head of that FIFO, honouring core backpressure.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready fragment handshake (in_ready = FIFO not full)
//   in_mask           lanes carried by the fragment
//   in_texels         32 bits per lane, lane i = bits[32i+:32]
//   in_tag            response tag, sampled on the first fragment only
//   in_last           final fragment of the response
//   rsp_valid/ready   response handshake to the core
//   rsp_texels/tag    assembled response (head FIFO entry)
//   perf_stalls       cycles with rsp_valid & !rsp_ready, saturating
//                     (present only when TEX_RSP_PERF_EN is defined)
//
// Configuration macro: TEX_RSP_PERF_EN
module vx_tex_rsp_gather #(
  parameter int NUM_LANES = 4,
  parameter int TAG_WIDTH = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [NUM_LANES-1:0]      in_mask,
  input  logic [NUM_LANES*32-1:0]   in_texels,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      rsp_valid,
  output logic [NUM_LANES*32-1:0]   rsp_texels,
  output logic [TAG_WIDTH-1:0]      rsp_tag,
  input  logic                      rsp_ready
`ifdef TEX_RSP_PERF_EN
  ,
  output logic [31:0]               perf_stalls
`endif
);

  localparam int TXW = NUM_LANES * 32;
  localparam int DW  = TXW + TAG_WIDTH;
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = $clog2(RSP_DEPTH + 1);

  typedef enum logic {S_IDLE = 1'b0, S_GATHER = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TXW-1:0]   r_stg_texels;
  logic [TAG_WIDTH-1:0] r_stg_tag;

  logic [DW-1:0]    r_mem [RSP_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [TXW-1:0]   r_rsp_texels;
  logic [TAG_WIDTH-1:0] r_rsp_tag;

  logic             w_fire;
  logic             w_pop;
  logic             w_push;
  logic             w_stage;
  logic [TXW-1:0]   w_merged;
  logic [TAG_WIDTH-1:0] w_tag;
  logic [PW-1:0]    w_rd_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  assign in_ready   = (r_count != CW'(RSP_DEPTH));
  assign rsp_valid  = (r_count != '0);
  assign rsp_texels = r_rsp_texels;
  assign rsp_tag    = r_rsp_tag;

  assign w_fire = in_valid & in_ready;
  assign w_pop  = rsp_valid & rsp_ready;

  // First fragment of a response starts from all-zero lanes and its own tag;
  // later fragments overlay the staged lanes and reuse the captured tag.
  always_comb begin
    w_merged = (r_state == S_GATHER) ? r_stg_texels : '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (in_mask[i]) w_merged[32*i +: 32] = in_texels[32*i +: 32];
    end
    w_tag = (r_state == S_GATHER) ? r_stg_tag : in_tag;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_fire && !in_last) w_state_nxt = S_GATHER;
      S_GATHER: if (w_fire && in_last)  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_push  = w_fire & in_last;
    w_stage = w_fire & ~in_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stg_texels <= '0;
      r_stg_tag    <= '0;
    end else if (w_stage) begin
      r_stg_texels <= w_merged;
      r_stg_tag    <= w_tag;
    end
  end

  // FIFO storage; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_merged, w_tag};
  end

  always_comb begin
    w_rd_nxt  = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    w_cnt_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_count + 1'b1;
      2'b01:   w_cnt_nxt = r_count - 1'b1;
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
    end
  end

  // Output register tracks the next head entry. When the new head is the slot
  // being written this cycle (FIFO was empty or drains to it), bypass the
  // write data. With nothing queued the last value is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_texels <= '0;
      r_rsp_tag    <= '0;
    end else if (w_cnt_nxt != '0) begin
      if (w_push && (w_rd_nxt == r_wr_ptr))
        {r_rsp_texels, r_rsp_tag} <= {w_merged, w_tag};
      else
        {r_rsp_texels, r_rsp_tag} <= r_mem[w_rd_nxt];
    end
  end

`ifdef TEX_RSP_PERF_EN
  logic [31:0] r_perf_stalls;
  assign perf_stalls = r_perf_stalls;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_perf_stalls <= '0;
    else if (rsp_valid && !rsp_ready && (r_perf_stalls != 32'hFFFF_FFFF))
      r_perf_stalls <= r_perf_stalls + 32'd1;
  end
`endif

`ifndef SYNTHESIS
  a_gather_tag: assert property (@(posedge clk) disable iff (reset)
    (r_state == S_GATHER && w_fire) |-> (in_tag == r_stg_tag))
    else $warning("in_tag differs from captured tag during gather");

  a_rsp_stable: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_texels) && $stable(rsp_tag)))
    else $error("rsp outputs changed while stalled");
`endif

endmodule

// File: tb/tb_vx_tex_rsp_gather.sv
module tb_vx_tex_rsp_gather;
  localparam int NL = 4;
  localparam int TW = 8;
  localparam int D  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [NL-1:0]     in_mask;
  logic [NL*32-1:0]  in_texels;
  logic [TW-1:0]     in_tag;
  logic              in_last;
  logic              in_ready;
  logic              rsp_valid;
  logic [NL*32-1:0]  rsp_texels;
  logic [TW-1:0]     rsp_tag;
  logic              rsp_ready;
`ifdef TEX_RSP_PERF_EN
  logic [31:0]       perf_stalls;
`endif

  vx_tex_rsp_gather #(.NUM_LANES(NL), .TAG_WIDTH(TW), .RSP_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_mask(in_mask), .in_texels(in_texels),
    .in_tag(in_tag), .in_last(in_last), .in_ready(in_ready),
    .rsp_valid(rsp_valid), .rsp_texels(rsp_texels), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready)
`ifdef TEX_RSP_PERF_EN
    , .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a response is the list of its fragments; lanes are
  // resolved only when the last fragment arrives (later fragment wins).
  typedef struct { logic [NL*32-1:0] tx; logic [TW-1:0] tag; } rsp_t;
  rsp_t              q[$];
  logic [NL-1:0]     fm[$];
  logic [NL*32-1:0]  ft[$];
  logic [TW-1:0]     cur_tag;
  bit                gathering;
  logic [NL*32-1:0]  last_tx;
  logic [TW-1:0]     last_tag;
  longint            stall_cnt;

  task automatic chk(input string name, input logic [NL*32-1:0] obs, input logic [NL*32-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete(); fm.delete(); ft.delete();
    gathering = 0; cur_tag = '0;
    last_tx = '0; last_tag = '0; stall_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, q.size() < D);
    chk("rsp_valid", rsp_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("rsp_texels", rsp_texels, q[0].tx);
      chk("rsp_tag", rsp_tag, q[0].tag);
    end else begin
      chk("hold_texels", rsp_texels, last_tx);
      chk("hold_tag", rsp_tag, last_tag);
    end
`ifdef TEX_RSP_PERF_EN
    chk("perf_stalls", perf_stalls, (stall_cnt > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : stall_cnt[31:0]);
`endif
  endtask

  // One clock: check state, drive inputs, advance model at the edge.
  task automatic cycle(input bit v, input logic [NL-1:0] m, input logic [NL*32-1:0] tx,
                       input logic [TW-1:0] tg, input bit l, input bit rr);
    bit fire, pop;
    logic [NL*32-1:0] r;
    @(negedge clk);
    check_outputs();
    in_valid = v; in_mask = m; in_texels = tx; in_tag = tg; in_last = l; rsp_ready = rr;
    fire = v && (q.size() < D);
    pop  = rr && (q.size() > 0);
    @(posedge clk);
    if (q.size() > 0 && !rr) stall_cnt++;
    if (pop) begin
      last_tx = q[0].tx; last_tag = q[0].tag;
      void'(q.pop_front());
    end
    if (fire) begin
      if (!gathering) cur_tag = tg;
      fm.push_back(m); ft.push_back(tx);
      if (l) begin
        r = '0;
        foreach (fm[f])
          for (int i = 0; i < NL; i++)
            if (fm[f][i]) r[32*i +: 32] = ft[f][32*i +: 32];
        q.push_back('{tx: r, tag: cur_tag});
        fm.delete(); ft.delete();
        gathering = 0;
      end else begin
        gathering = 1;
      end
    end
  endtask

  function automatic logic [NL*32-1:0] rnd_tx();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input bit rr);
    cycle(0, '0, '0, '0, 0, rr);
  endtask

  logic [NL*32-1:0] t0, t1;

  initial begin
    reset = 1'b1;
    in_valid = 0; in_mask = '0; in_texels = '0; in_tag = '0; in_last = 0; rsp_ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_texels", rsp_texels, 0);
    chk("reset_tag", rsp_tag, 0);
    @(negedge clk);
    reset = 1'b0;

    // single full fragment
    t0 = rnd_tx();
    cycle(1, 4'hF, t0, 8'h3C, 1, 1);
    idle(1);
    idle(1);

    // two fragments merged, tag from the first
    t0 = rnd_tx(); t1 = rnd_tx();
    cycle(1, 4'b0011, t0, 8'h11, 0, 1);
    cycle(1, 4'b1100, t1, 8'h22, 1, 1);
    idle(1);
    idle(1);

    // sparse mask: unwritten lanes read zero
    cycle(1, 4'b0101, rnd_tx(), 8'h5A, 1, 1);
    idle(1);
    idle(1);

    // fill FIFO under backpressure, then stall
    for (int k = 0; k < 5; k++) cycle(1, 4'hF, rnd_tx(), 8'(8'hA0 + k), 1, 0);
    repeat (3) idle(0);
    // single pop while full; fragment offered but refused this edge
    cycle(1, 4'hF, rnd_tx(), 8'hB0, 1, 1);
    cycle(1, 4'hF, rnd_tx(), 8'hB1, 1, 0);
    idle(0);
    // drain across pointer wrap
    repeat (6) idle(1);

    // reset mid-gather with two entries queued
    cycle(1, 4'hF, rnd_tx(), 8'hC0, 1, 0);
    cycle(1, 4'hF, rnd_tx(), 8'hC1, 1, 0);
    cycle(1, 4'b1111, rnd_tx(), 8'hC2, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_texels", rsp_texels, 0);
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(1, 4'b0101, rnd_tx(), 8'hD0, 1, 1);
    idle(1);
    idle(1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      bit v, l, rr;
      logic [TW-1:0] tg;
      v  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 2) != 0);
      tg = gathering ? cur_tag : TW'($urandom);
      cycle(v, NL'($urandom), rnd_tx(), tg, l, rr);
    end
    repeat (8) idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
